// File: rtl/pll_reset_pkg.sv
// ---------------------------------------------------------------------------
// pll_reset_pkg
// Shared definitions for the PLL reset sequencer: state encoding, default
// timing constants, a width helper for the counters and the decode from a
// state to the three reset/status outputs.
// No ports (package).
// ---------------------------------------------------------------------------
package pll_reset_pkg;

    localparam int DEF_RST_CYCLES   = 16;
    localparam int DEF_LOCK_STABLE  = 1024;
    localparam int DEF_LOCK_TIMEOUT = 742500;
    localparam int DEF_RETRY_W      = 4;

    // Encoding 2'd3 is unused and is treated as RESET_PLL.
    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        RUN       = 2'd2
    } pll_state_e;

    // Counter width able to hold 0..value-1, never narrower than 1 bit.
    function automatic int clog2_min1(input int value);
        if (value <= 2) begin
            return 1;
        end
        return $clog2(value);
    endfunction

    // {pll_rst, core_rst, pll_ok} for a given state.
    function automatic logic [2:0] decode_outputs(input pll_state_e s);
        return {(s != WAIT_LOCK) && (s != RUN), (s != RUN), (s == RUN)};
    endfunction

endpackage

// File: rtl/pll_reset_ctrl_if.sv
// ---------------------------------------------------------------------------
// pll_reset_ctrl_if
// Groups the PLL-facing and core-facing signals of the reset sequencer.
//   pll_locked  : PLL lock indication, asynchronous to refclk
//   restart_req : one-cycle request to re-run the PLL reset sequence
//   pll_rst     : reset to the PLL, active high
//   core_rst    : reset to core logic, active high
//   pll_ok      : high while the sequencer is in RUN
//   retry_cnt   : saturating count of lock timeouts plus lock losses
//   state_o     : current state encoding, for debug
// master = the sequencer, slave = the PLL/system side.
// ---------------------------------------------------------------------------
interface pll_reset_ctrl_if #(
    parameter int RETRY_W = 4
);
    logic               pll_locked;
    logic               restart_req;
    logic               pll_rst;
    logic               core_rst;
    logic               pll_ok;
    logic [RETRY_W-1:0] retry_cnt;
    logic [1:0]         state_o;

    modport master (
        input  pll_locked,
        input  restart_req,
        output pll_rst,
        output core_rst,
        output pll_ok,
        output retry_cnt,
        output state_o
    );

    modport slave (
        output pll_locked,
        output restart_req,
        input  pll_rst,
        input  core_rst,
        input  pll_ok,
        input  retry_cnt,
        input  state_o
    );
endinterface

// File: rtl/pll_lock_sync.sv
// ---------------------------------------------------------------------------
// pll_lock_sync
// Two-flop synchronizer for asynchronous status inputs, synchronous reset
// to 0. Output follows the input with two clock cycles of latency.
//   clk       : destination clock
//   rst       : synchronous active-high reset
//   async_sig : asynchronous input bits
//   sync_sig  : synchronized output bits
// ---------------------------------------------------------------------------
module pll_lock_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_sig,
    output logic [WIDTH-1:0] sync_sig
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_sig;
            sync_q <= meta_q;
        end
    end

    assign sync_sig = sync_q;

endmodule

// File: rtl/pll_reset_ctrl.sv
// ---------------------------------------------------------------------------
// pll_reset_ctrl
// Reset sequencer on the PLL reference-clock side. Holds the PLL in reset
// for RST_CYCLES, waits for lock to be stable for LOCK_STABLE cycles before
// releasing the core, and re-runs the PLL reset on lock loss, on lock
// timeout (LOCK_TIMEOUT cycles in WAIT_LOCK) or on a restart request.
//   refclk : reference clock, sole clock
//   rst    : synchronous active-high reset
//   bus    : pll_reset_ctrl_if.master (pll_locked, restart_req in;
//            pll_rst, core_rst, pll_ok, retry_cnt, state_o out)
// ---------------------------------------------------------------------------
module pll_reset_ctrl
    import pll_reset_pkg::*;
#(
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int RETRY_W      = DEF_RETRY_W
) (
    input  logic              refclk,
    input  logic              rst,
    pll_reset_ctrl_if.master  bus
);

    localparam int CYC_W = clog2_min1(RST_CYCLES);
    localparam int STB_W = clog2_min1(LOCK_STABLE);
    localparam int TMO_W = clog2_min1(LOCK_TIMEOUT);

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

    logic               locked_s;
    pll_state_e         state;
    logic [CYC_W-1:0]   cyc_cnt;
    logic [STB_W-1:0]   stb_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [RETRY_W-1:0] retry_q;
    logic               pll_rst_q;
    logic               core_rst_q;
    logic               pll_ok_q;

    // The only place pll_locked is sampled.
    pll_lock_sync #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk       (refclk),
        .rst       (rst),
        .async_sig (bus.pll_locked),
        .sync_sig  (locked_s)
    );

    // Every transition clears all three counters and loads the outputs
    // decoded from the destination state, so outputs switch on the same edge
    // as the state register. Staying in a state leaves the outputs alone.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state   <= RESET_PLL;
            cyc_cnt <= '0;
            stb_cnt <= '0;
            tmo_cnt <= '0;
            retry_q <= '0;
            {pll_rst_q, core_rst_q, pll_ok_q} <= decode_outputs(RESET_PLL);
        end else if (bus.restart_req) begin
            // Restart is not a failure, so the retry count is left alone.
            state   <= RESET_PLL;
            cyc_cnt <= '0;
            stb_cnt <= '0;
            tmo_cnt <= '0;
            {pll_rst_q, core_rst_q, pll_ok_q} <= decode_outputs(RESET_PLL);
        end else begin
            case (state)
                RESET_PLL: begin
                    if (cyc_cnt == CYC_LAST) begin
                        state   <= WAIT_LOCK;
                        cyc_cnt <= '0;
                        stb_cnt <= '0;
                        tmo_cnt <= '0;
                        {pll_rst_q, core_rst_q, pll_ok_q} <= decode_outputs(WAIT_LOCK);
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // Stable lock takes priority over a coincident timeout.
                    if (locked_s && (stb_cnt == STB_LAST)) begin
                        state   <= RUN;
                        cyc_cnt <= '0;
                        stb_cnt <= '0;
                        tmo_cnt <= '0;
                        {pll_rst_q, core_rst_q, pll_ok_q} <= decode_outputs(RUN);
                    end else if (tmo_cnt == TMO_LAST) begin
                        state   <= RESET_PLL;
                        cyc_cnt <= '0;
                        stb_cnt <= '0;
                        tmo_cnt <= '0;
                        if (retry_q != '1) begin
                            retry_q <= retry_q + 1'b1;
                        end
                        {pll_rst_q, core_rst_q, pll_ok_q} <= decode_outputs(RESET_PLL);
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        stb_cnt <= locked_s ? stb_cnt + 1'b1 : '0;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state   <= RESET_PLL;
                        cyc_cnt <= '0;
                        stb_cnt <= '0;
                        tmo_cnt <= '0;
                        if (retry_q != '1) begin
                            retry_q <= retry_q + 1'b1;
                        end
                        {pll_rst_q, core_rst_q, pll_ok_q} <= decode_outputs(RESET_PLL);
                    end
                end
                default: begin
                    state   <= RESET_PLL;
                    cyc_cnt <= '0;
                    stb_cnt <= '0;
                    tmo_cnt <= '0;
                    {pll_rst_q, core_rst_q, pll_ok_q} <= decode_outputs(RESET_PLL);
                end
            endcase
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.core_rst  = core_rst_q;
    assign bus.pll_ok    = pll_ok_q;
    assign bus.retry_cnt = retry_q;
    assign bus.state_o   = state;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_ctrl
// Self-checking bench for pll_reset_ctrl with short timing parameters.
// A table of hand-derived vectors walks the main scenarios; a reference
// model tracks time-in-phase and the trailing run of synchronized lock
// samples and is compared with the DUT after every clock.
// ---------------------------------------------------------------------------
module tb_pll_reset_ctrl;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_STABLE  = 8;
    localparam int LOCK_TIMEOUT = 64;
    localparam int RETRY_W      = 2;
    localparam int RETRY_MAX    = (1 << RETRY_W) - 1;

    logic refclk = 1'b0;
    logic rst;

    pll_reset_ctrl_if #(.RETRY_W(RETRY_W)) bus ();

    pll_reset_ctrl #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .RETRY_W      (RETRY_W)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 refclk = ~refclk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst;
        logic       locked;
        logic       restart;
        int         cycles;
        logic [6:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    // Reference model: phase 0/1/2, edges spent in the phase, consecutive
    // synchronized-locked cycles seen in the phase, retry count, and the
    // two lock samples still in flight through the synchronizer.
    int m_phase = 0;
    int m_age   = 0;
    int m_run   = 0;
    int m_retry = 0;
    bit m_dq[$];

    // {pll_rst, core_rst, pll_ok, retry_cnt, state_o}
    function automatic logic [6:0] expOf(input int st, input int rt);
        return {(st == 0), (st != 2), (st == 2), 2'(rt), 2'(st)};
    endfunction

    function automatic vec_t mk(input logic r, input logic l, input logic q,
                                input int n, input int st, input int rt,
                                input string name);
        vec_t v;
        v.rst     = r;
        v.locked  = l;
        v.restart = q;
        v.cycles  = n;
        v.exp     = expOf(st, rt);
        v.name    = name;
        return v;
    endfunction

    function automatic void enterPhase(input int p);
        m_phase = p;
        m_age   = 0;
        m_run   = 0;
    endfunction

    function automatic void bumpRetry();
        if (m_retry < RETRY_MAX) m_retry = m_retry + 1;
    endfunction

    function automatic void modelStep(input logic r, input logic l, input logic q);
        bit ls;
        if (r) begin
            enterPhase(0);
            m_retry = 0;
            m_dq = '{1'b0, 1'b0};
            return;
        end
        ls = m_dq.pop_front();
        m_dq.push_back(l);
        if (q) begin
            enterPhase(0);
            return;
        end
        m_age = m_age + 1;
        case (m_phase)
            0: if (m_age == RST_CYCLES) enterPhase(1);
            1: begin
                m_run = ls ? m_run + 1 : 0;
                if (ls && m_run == LOCK_STABLE) begin
                    enterPhase(2);
                end else if (m_age == LOCK_TIMEOUT) begin
                    enterPhase(0);
                    bumpRetry();
                end
            end
            default: if (!ls) begin
                enterPhase(0);
                bumpRetry();
            end
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [6:0] exp);
        logic [6:0] got;
        got = {bus.pll_rst, bus.core_rst, bus.pll_ok, bus.retry_cnt, bus.state_o};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: rst/core/ok/retry/state got %b required %b at %0t",
                     name, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model and
    // compare just after the edge.
    task automatic applyStimulus(input logic r, input logic l, input logic q);
        rst             = r;
        bus.pll_locked  = l;
        bus.restart_req = q;
        @(posedge refclk);
        modelStep(r, l, q);
        #1;
        checkOutput("model", expOf(m_phase, m_retry));
    endtask

    initial begin
        logic lk;
        rst             = 1'b1;
        bus.pll_locked  = 1'b0;
        bus.restart_req = 1'b0;
        m_dq            = '{1'b0, 1'b0};

        // rst, locked, restart, cycles, expected state, expected retry
        vecs.push_back(mk(1, 0, 0,  3, 0, 0, "reset_state"));
        vecs.push_back(mk(0, 0, 0,  3, 0, 0, "pll_rst_held"));
        vecs.push_back(mk(0, 0, 0,  1, 1, 0, "pll_rst_4_cycles"));
        vecs.push_back(mk(0, 0, 0, 10, 1, 0, "wait_unlocked"));
        vecs.push_back(mk(0, 1, 0,  9, 1, 0, "lock_not_yet_stable"));
        vecs.push_back(mk(0, 1, 0,  1, 2, 0, "run_after_2_plus_8"));
        vecs.push_back(mk(0, 0, 0,  1, 2, 0, "drop_edge1"));
        vecs.push_back(mk(0, 1, 0,  1, 2, 0, "drop_edge2"));
        vecs.push_back(mk(0, 1, 0,  1, 0, 1, "lock_loss_3_cycles"));
        vecs.push_back(mk(0, 1, 0,  3, 0, 1, "relock_reset"));
        vecs.push_back(mk(0, 1, 0,  1, 1, 1, "relock_wait"));
        vecs.push_back(mk(0, 1, 0,  7, 1, 1, "relock_stable"));
        vecs.push_back(mk(0, 1, 0,  1, 2, 1, "relock_run"));
        vecs.push_back(mk(0, 1, 1,  1, 0, 1, "restart_from_run"));
        vecs.push_back(mk(0, 1, 0,  3, 0, 1, "glitch_reset"));
        vecs.push_back(mk(0, 1, 0,  1, 1, 1, "glitch_wait"));
        vecs.push_back(mk(0, 1, 0,  5, 1, 1, "glitch_stb5"));
        vecs.push_back(mk(0, 0, 0,  1, 1, 1, "glitch_low"));
        vecs.push_back(mk(0, 1, 0,  1, 1, 1, "glitch_high"));
        vecs.push_back(mk(0, 1, 0,  1, 1, 1, "glitch_no_early_run"));
        vecs.push_back(mk(0, 1, 0,  7, 1, 1, "glitch_restable"));
        vecs.push_back(mk(0, 1, 0,  1, 2, 1, "glitch_full_8_run"));
        vecs.push_back(mk(0, 0, 0,  3, 0, 2, "loss_before_timeout"));
        vecs.push_back(mk(0, 0, 0,  3, 0, 2, "tmo_reset_a"));
        vecs.push_back(mk(0, 0, 0,  1, 1, 2, "tmo_wait_a"));
        vecs.push_back(mk(0, 0, 0, 63, 1, 2, "tmo_63_a"));
        vecs.push_back(mk(0, 0, 0,  1, 0, 3, "timeout_a"));
        vecs.push_back(mk(0, 0, 0,  3, 0, 3, "tmo_reset_b"));
        vecs.push_back(mk(0, 0, 0,  1, 1, 3, "tmo_wait_b"));
        vecs.push_back(mk(0, 0, 0, 63, 1, 3, "tmo_63_b"));
        vecs.push_back(mk(0, 0, 0,  1, 0, 3, "retry_saturated"));
        vecs.push_back(mk(0, 0, 0,  4, 1, 3, "tmo_wait_c"));
        vecs.push_back(mk(0, 1, 0,  3, 1, 3, "short_lock_in_wait"));
        vecs.push_back(mk(0, 0, 0, 60, 1, 3, "tmo_keeps_running"));
        vecs.push_back(mk(0, 0, 0,  1, 0, 3, "timeout_unaffected"));
        vecs.push_back(mk(0, 1, 0,  4, 1, 3, "restart_prep_wait"));
        vecs.push_back(mk(0, 1, 0,  7, 1, 3, "restart_prep_stable"));
        vecs.push_back(mk(0, 1, 0,  1, 2, 3, "restart_prep_run"));
        vecs.push_back(mk(0, 1, 1,  1, 0, 3, "restart_mid_run"));
        vecs.push_back(mk(0, 1, 0,  2, 0, 3, "restart_reset_2"));
        vecs.push_back(mk(0, 1, 1,  1, 0, 3, "restart_in_reset"));
        vecs.push_back(mk(0, 1, 0,  3, 0, 3, "restart_clears_cyc"));
        vecs.push_back(mk(0, 1, 0,  1, 1, 3, "restart_4_cycles"));
        vecs.push_back(mk(0, 1, 0,  5, 1, 3, "mid_wait"));
        vecs.push_back(mk(1, 1, 0,  1, 0, 0, "rst_mid_wait"));
        vecs.push_back(mk(0, 1, 0,  4, 1, 0, "post_rst_wait"));
        vecs.push_back(mk(0, 1, 0,  7, 1, 0, "post_rst_stable"));
        vecs.push_back(mk(0, 1, 0,  1, 2, 0, "post_rst_run"));
        vecs.push_back(mk(0, 1, 1,  1, 0, 0, "restart_no_retry"));

        for (int i = 0; i < vecs.size(); i++) begin
            for (int c = 0; c < vecs[i].cycles; c++) begin
                applyStimulus(vecs[i].rst, vecs[i].locked, vecs[i].restart);
            end
            checkOutput(vecs[i].name, vecs[i].exp);
        end

        // Random lock behaviour with occasional restarts and resets.
        lk = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            logic r;
            logic q;
            if ($urandom_range(0, 29) == 0) lk = ~lk;
            r = ($urandom_range(0, 1499) == 0);
            q = ($urandom_range(0, 199) == 0);
            applyStimulus(r, lk, q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_reset_ctrl.md
Name: pll_reset_ctrl

Overview:
Reset sequencer on the PLL reference-clock side. It drives the PLL's rst input and monitors the PLL's locked output. It releases the core reset only after lock has been stable for a programmed time. It re-runs the PLL reset on lock loss, on lock timeout, or on a software restart request.

Parameters:
RST_CYCLES, 16, refclk cycles pll_rst is held high per reset attempt (min 2)
LOCK_STABLE, 1024, consecutive synchronized-locked cycles required before core release (min 2)
LOCK_TIMEOUT, 742500, max refclk cycles in WAIT_LOCK before retry (10 ms at 74.25 MHz); must exceed LOCK_STABLE
RETRY_W, 4, width of the saturating retry counter

Ports:
refclk  in  1  reference clock (74.25 MHz), sole clock
rst  in  1  synchronous active-high reset
pll_locked  in  1  PLL locked, asynchronous to refclk
restart_req  in  1  single-cycle request to re-run the PLL reset sequence
pll_rst  out  1  reset to PLL, active high
core_rst  out  1  reset to core logic, active high
pll_ok  out  1  high while in RUN
retry_cnt  out  RETRY_W  count of lock timeouts plus lock losses, saturating
state_o  out  2  current state encoding, for debug

Behaviour:
- Reset (rst=1 at a refclk edge):
  - state=RESET_PLL; pll_rst=1, core_rst=1, pll_ok=0.
  - retry_cnt=0; all counters 0; sync flops 0.
- pll_locked passes through a 2-FF synchronizer to give locked_s (2-cycle latency). No other logic samples pll_locked.
- States: RESET_PLL=0, WAIT_LOCK=1, RUN=2 (3 unused; it decodes to RESET_PLL).
- RESET_PLL:
  - cyc_cnt increments each cycle.
  - When cyc_cnt==RST_CYCLES-1: go to WAIT_LOCK and clear cyc_cnt.
  - Net effect: pll_rst is high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - tmo_cnt increments every cycle.
  - stb_cnt increments while locked_s=1 and clears to 0 when locked_s=0.
  - If locked_s=1 and stb_cnt==LOCK_STABLE-1: go to RUN.
  - Else if tmo_cnt==LOCK_TIMEOUT-1: go to RESET_PLL and increment retry_cnt.
  - If both conditions hit in the same cycle, RUN wins.
- RUN: if locked_s=0, go to RESET_PLL and increment retry_cnt.
- restart_req=1 in any state:
  - Go to RESET_PLL with all counters cleared, including when already in RESET_PLL.
  - retry_cnt is not incremented.
- Priority: rst > restart_req > lock-loss/timeout/stable transitions.
- Outputs are registered and decoded from next_state, so they change on the same edge as state:
  - pll_rst = (state==RESET_PLL)
  - core_rst = (state!=RUN)
  - pll_ok = (state==RUN)
- retry_cnt saturates at 2^RETRY_W-1 and never wraps.
- Counter widths are $clog2 of their terminal value, minimum 1 bit. Counters clear on every state entry.
- Latency:
  - Lock-loss detection takes 2 cycles (synchronizer) plus 1 cycle (state register).
  - Lock glitches shorter than 1 cycle may be missed; this is acceptable.
- Glitch on locked during WAIT_LOCK: stb_cnt restarts from 0 and tmo_cnt keeps running.

Decomposition:
- Package pll_reset_pkg holds:
  - state typedef and encodings (RESET_PLL/WAIT_LOCK/RUN);
  - default parameter constants;
  - a clog2-min-1 helper function.
- One sub-module, pll_lock_sync: 2-FF synchronizer with sync reset to 0, also reusable for other async status inputs.
- The FSM and counters live in pll_reset_ctrl.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, RETRY_W=2.
1. Hold rst for 3 cycles, then release with pll_locked=0. Check: pll_rst=1 for exactly 4 cycles after release, then 0; core_rst=1; state_o=1.
2. Raise pll_locked 10 cycles into WAIT_LOCK. Check: core_rst falls and pll_ok rises exactly 2+8 cycles after the edge; state_o=2; retry_cnt=0.
3. Keep pll_locked=0. Check: after 64 WAIT_LOCK cycles, pll_rst re-asserts for 4 cycles and retry_cnt=1. After 4 more timeouts, retry_cnt holds at 3 (saturated).
4. In RUN, drop pll_locked for 1 cycle. Check: core_rst=1 and pll_rst=1 exactly 3 cycles after the drop; retry_cnt increments by 1; normal re-lock follows.
5. In WAIT_LOCK, pulse pll_locked 1→0 at stb_cnt=5. Check: stb_cnt restarts; RUN is entered only after a full 8-cycle stable run; tmo_cnt is unaffected.
6. Pulse restart_req mid-RUN and again 2 cycles into RESET_PLL. Check: pll_rst high for 4 cycles measured from the second pulse; retry_cnt unchanged; assert rst mid-WAIT_LOCK and all outputs return to reset values next edge.
